// File: rtl/xor_stream_parity_pkg.sv
// Shared types and default sizes for the XOR-stage frame collector.
// State encoding and parameter defaults only; no logic.
package xor_stream_parity_pkg;

    typedef enum logic {FILL, HOLD} xsp_state_t;

    localparam int XSP_FRAME_LEN_DEF = 8;
    localparam int XSP_CNT_W_DEF     = 16;

endpackage

// File: rtl/xor_stream_parity.sv
// Packs FRAME_LEN serial bits (first bit -> MSB) into a word with running parity.
// Latency: last bit accepted at edge N -> out_valid in the cycle after edge N; one HOLD cycle minimum.
// Backpressure: in_ready drops for the whole HOLD state; XOR_STREAM_PARITY_ODD_EN selects odd parity.
module xor_stream_parity
    import xor_stream_parity_pkg::*;
#(
    parameter int FRAME_LEN = XSP_FRAME_LEN_DEF,
    parameter int CNT_W     = XSP_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAME_LEN-1:0] out_data,
    output logic                 out_parity,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

`ifdef XOR_STREAM_PARITY_ODD_EN
    localparam logic PAR_INIT = 1'b1;
`else
    localparam logic PAR_INIT = 1'b0;
`endif

    xsp_state_t           r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [FRAME_LEN-1:0] r_data;
    logic                 r_parity;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_frame_cnt;

    // Seeding the parity flop with PAR_INIT folds the odd-mode inversion into the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_parity    <= PAR_INIT;
            r_idx       <= '0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (in_valid) begin
                        r_data   <= {r_data[FRAME_LEN-2:0], in_bit};
                        r_parity <= r_parity ^ in_bit;
                        if (r_idx == IDX_LAST) begin
                            r_idx       <= '0;
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= FILL;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_parity    <= PAR_INIT;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    // Gated by rst so upstream sees no readiness while reset is held.
    assign in_ready   = r_in_ready & ~rst;
    assign out_valid  = r_out_valid;
    assign out_data   = r_data;
    assign out_parity = r_parity;
    assign frame_cnt  = r_frame_cnt;

endmodule
